// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-side operand forwarding and load-use hazard detection.
// Fields captured at the end of ID drive the ALU operands through a zero-latency bypass mux.
module id_ex_stage (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic        i_id_valid,
  input  logic [4:0]  i_id_rs,
  input  logic [4:0]  i_id_rt,
  input  logic [4:0]  i_id_rd,
  input  logic [31:0] i_id_rs_data,
  input  logic [31:0] i_id_rt_data,
  input  logic [15:0] i_id_imm,
  input  logic [4:0]  i_id_shamt,
  input  logic [2:0]  i_id_alu_ctrl,
  input  logic        i_id_alu_src,
  input  logic        i_id_sign_ext,
  input  logic        i_id_shift,
  input  logic        i_id_uses_rt,
  input  logic        i_id_dst_sel,
  input  logic        i_id_reg_write,
  input  logic        i_id_mem_read,
  input  logic        i_id_mem_write,
  input  logic        i_exmem_reg_write,
  input  logic [4:0]  i_exmem_rd,
  input  logic [31:0] i_exmem_result,
  input  logic        i_memwb_reg_write,
  input  logic [4:0]  i_memwb_rd,
  input  logic [31:0] i_memwb_result,
  output logic [31:0] o_alu_a,
  output logic [31:0] o_alu_b,
  output logic [2:0]  o_alu_ctrl,
  output logic        o_ex_valid,
  output logic [4:0]  o_ex_dst,
  output logic        o_ex_reg_write,
  output logic        o_ex_mem_read,
  output logic        o_ex_mem_write,
  output logic [31:0] o_ex_store_data,
  output logic        o_load_use_hazard
);

  logic        r_valid;
  logic [4:0]  r_rs;
  logic [4:0]  r_rt;
  logic [4:0]  r_dst;
  logic [31:0] r_rs_data;
  logic [31:0] r_rt_data;
  logic [31:0] r_imm;
  logic [4:0]  r_shamt;
  logic [2:0]  r_alu_ctrl;
  logic        r_alu_src;
  logic        r_shift;
  logic        r_reg_write;
  logic        r_mem_read;
  logic        r_mem_write;

  logic        w_hazard;
  logic        w_load_en;
  logic        w_bubble;
  logic [31:0] w_imm_ext;
  logic [31:0] w_rs_cap;
  logic [31:0] w_rt_cap;
  logic [31:0] w_fwd_rs;
  logic [31:0] w_fwd_rt;

  // Load-use detection against the instruction in ID; suppressed while the pipe is frozen.
  always_comb begin
    w_hazard = !i_stall && r_valid && r_mem_read && (r_dst != 5'd0) && i_id_valid &&
               ((r_dst == i_id_rs) || (i_id_uses_rt && (r_dst == i_id_rt)));
    // Reset overrides stall; a bubble is loaded on reset, flush or hazard.
    w_load_en = i_reset || !i_stall;
    w_bubble  = i_reset || i_flush || w_hazard;
  end

  // Capture-side values: immediate extension and write-back bypass of the register file.
  always_comb begin
    w_imm_ext = i_id_sign_ext ? {{16{i_id_imm[15]}}, i_id_imm} : {16'd0, i_id_imm};
    w_rs_cap  = i_id_rs_data;
    w_rt_cap  = i_id_rt_data;
    if (i_memwb_reg_write && (i_memwb_rd != 5'd0) && (i_memwb_rd == i_id_rs)) begin
      w_rs_cap = i_memwb_result;
    end
    if (i_memwb_reg_write && (i_memwb_rd != 5'd0) && (i_memwb_rd == i_id_rt)) begin
      w_rt_cap = i_memwb_result;
    end
  end

  // ID/EX register: hold on stall, bubble on reset/flush/hazard, otherwise capture.
  always_ff @(posedge i_clk) begin
    if (w_load_en) begin
      if (w_bubble) begin
        r_valid     <= 1'b0;
        r_rs        <= 5'd0;
        r_rt        <= 5'd0;
        r_dst       <= 5'd0;
        r_rs_data   <= 32'd0;
        r_rt_data   <= 32'd0;
        r_imm       <= 32'd0;
        r_shamt     <= 5'd0;
        r_alu_ctrl  <= 3'b000;
        r_alu_src   <= 1'b0;
        r_shift     <= 1'b0;
        r_reg_write <= 1'b0;
        r_mem_read  <= 1'b0;
        r_mem_write <= 1'b0;
      end else begin
        r_valid     <= i_id_valid;
        r_rs        <= i_id_rs;
        r_rt        <= i_id_rt;
        r_dst       <= i_id_dst_sel ? i_id_rd : i_id_rt;
        r_rs_data   <= w_rs_cap;
        r_rt_data   <= w_rt_cap;
        r_imm       <= w_imm_ext;
        r_shamt     <= i_id_shamt;
        r_alu_ctrl  <= i_id_alu_ctrl;
        r_alu_src   <= i_id_alu_src;
        r_shift     <= i_id_shift;
        r_reg_write <= i_id_reg_write & i_id_valid;
        r_mem_read  <= i_id_mem_read  & i_id_valid;
        r_mem_write <= i_id_mem_write & i_id_valid;
      end
    end
  end

  // EX-side forwarding: EX/MEM beats MEM/WB; register 0 never forwards.
  always_comb begin
    w_fwd_rs = r_rs_data;
    if (i_exmem_reg_write && (i_exmem_rd != 5'd0) && (i_exmem_rd == r_rs)) begin
      w_fwd_rs = i_exmem_result;
    end else if (i_memwb_reg_write && (i_memwb_rd != 5'd0) && (i_memwb_rd == r_rs)) begin
      w_fwd_rs = i_memwb_result;
    end
    w_fwd_rt = r_rt_data;
    if (i_exmem_reg_write && (i_exmem_rd != 5'd0) && (i_exmem_rd == r_rt)) begin
      w_fwd_rt = i_exmem_result;
    end else if (i_memwb_reg_write && (i_memwb_rd != 5'd0) && (i_memwb_rd == r_rt)) begin
      w_fwd_rt = i_memwb_result;
    end
  end

  // Operand selection and registered control outputs.
  always_comb begin
    o_alu_a           = r_shift ? {27'd0, r_shamt} : w_fwd_rs;
    o_alu_b           = r_alu_src ? r_imm : w_fwd_rt;
    o_alu_ctrl        = r_alu_ctrl;
    o_ex_valid        = r_valid;
    o_ex_dst          = r_dst;
    o_ex_reg_write    = r_reg_write;
    o_ex_mem_read     = r_mem_read;
    o_ex_mem_write    = r_mem_write;
    o_ex_store_data   = w_fwd_rt;
    o_load_use_hazard = w_hazard;
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset, stall, flush, id_valid;
  logic [4:0]  id_rs, id_rt, id_rd, id_shamt;
  logic [31:0] id_rs_data, id_rt_data;
  logic [15:0] id_imm;
  logic [2:0]  id_alu_ctrl;
  logic        id_alu_src, id_sign_ext, id_shift, id_uses_rt, id_dst_sel;
  logic        id_reg_write, id_mem_read, id_mem_write;
  logic        exmem_reg_write, memwb_reg_write;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_result;
  logic [31:0] alu_a, alu_b, ex_store_data;
  logic [2:0]  alu_ctrl;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, load_use_hazard;
  logic [4:0]  ex_dst;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .i_clk(clk), .i_reset(reset), .i_stall(stall), .i_flush(flush), .i_id_valid(id_valid),
    .i_id_rs(id_rs), .i_id_rt(id_rt), .i_id_rd(id_rd),
    .i_id_rs_data(id_rs_data), .i_id_rt_data(id_rt_data), .i_id_imm(id_imm),
    .i_id_shamt(id_shamt), .i_id_alu_ctrl(id_alu_ctrl), .i_id_alu_src(id_alu_src),
    .i_id_sign_ext(id_sign_ext), .i_id_shift(id_shift), .i_id_uses_rt(id_uses_rt),
    .i_id_dst_sel(id_dst_sel), .i_id_reg_write(id_reg_write), .i_id_mem_read(id_mem_read),
    .i_id_mem_write(id_mem_write),
    .i_exmem_reg_write(exmem_reg_write), .i_exmem_rd(exmem_rd), .i_exmem_result(exmem_result),
    .i_memwb_reg_write(memwb_reg_write), .i_memwb_rd(memwb_rd), .i_memwb_result(memwb_result),
    .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_ctrl(alu_ctrl), .o_ex_valid(ex_valid),
    .o_ex_dst(ex_dst), .o_ex_reg_write(ex_reg_write), .o_ex_mem_read(ex_mem_read),
    .o_ex_mem_write(ex_mem_write), .o_ex_store_data(ex_store_data),
    .o_load_use_hazard(load_use_hazard)
  );

  task automatic idle();
    reset = 0; stall = 0; flush = 0; id_valid = 0;
    id_rs = 0; id_rt = 0; id_rd = 0; id_shamt = 0; id_rs_data = 0; id_rt_data = 0;
    id_imm = 0; id_alu_ctrl = 0; id_alu_src = 0; id_sign_ext = 0; id_shift = 0;
    id_uses_rt = 0; id_dst_sel = 0; id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
    exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
    memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    id_valid = 1; id_rs = 3; id_rs_data = 32'h55; id_alu_ctrl = 3'b010; id_reg_write = 1;
    reset = 1;
    tick();
    tick();
    reset = 0; id_valid = 0;
    #1;
    checks++;
    if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_ctrl !== 3'b000) begin
      errors++;
      $display("FAIL reset_alu got a=%h b=%h ctrl=%b exp 0", alu_a, alu_b, alu_ctrl);
    end
    checks++;
    if ({ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, load_use_hazard} !== 5'd0 ||
        ex_dst !== 5'd0 || ex_store_data !== 32'd0) begin
      errors++;
      $display("FAIL reset_ctrl got v=%b rw=%b mr=%b mw=%b h=%b dst=%0d sd=%h exp 0",
               ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, load_use_hazard,
               ex_dst, ex_store_data);
    end
  endtask

  task automatic test_immediate();
    idle();
    id_valid = 1; id_rs = 3; id_rt = 5; id_rs_data = 32'h10; id_imm = 16'hFFFF;
    id_sign_ext = 1; id_alu_src = 1; id_alu_ctrl = 3'b010; id_reg_write = 1;
    tick();
    idle();
    #1;
    checks++;
    if (alu_a !== 32'h10 || alu_b !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL addi_ops got a=%h b=%h exp a=00000010 b=ffffffff", alu_a, alu_b);
    end
    checks++;
    if (alu_ctrl !== 3'b010 || ex_dst !== 5'd5 || ex_valid !== 1'b1 || ex_reg_write !== 1'b1)
    begin
      errors++;
      $display("FAIL addi_ctrl got ctrl=%b dst=%0d v=%b rw=%b exp 010 5 1 1",
               alu_ctrl, ex_dst, ex_valid, ex_reg_write);
    end
    // ORI with zero extension of a negative-looking immediate, rd-destination ignored
    id_valid = 1; id_rs = 1; id_rt = 6; id_rd = 20; id_rs_data = 32'h7; id_imm = 16'h8001;
    id_alu_src = 1; id_alu_ctrl = 3'b001; id_reg_write = 1;
    tick();
    idle();
    #1;
    checks++;
    if (alu_b !== 32'h0000_8001 || alu_ctrl !== 3'b001 || ex_dst !== 5'd6) begin
      errors++;
      $display("FAIL ori_zext got b=%h ctrl=%b dst=%0d exp 00008001 001 6",
               alu_b, alu_ctrl, ex_dst);
    end
    // Invalid ID slot: control bits gated off
    id_valid = 0; id_rt = 4; id_reg_write = 1; id_mem_write = 1;
    tick();
    idle();
    #1;
    checks++;
    if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_mem_write !== 1'b0) begin
      errors++;
      $display("FAIL gate_invalid got v=%b rw=%b mw=%b exp 0 0 0",
               ex_valid, ex_reg_write, ex_mem_write);
    end
  endtask

  task automatic test_forwarding();
    idle();
    id_valid = 1; id_rs = 4; id_rt = 6; id_rs_data = 32'h1111; id_rt_data = 32'h2222;
    id_alu_ctrl = 3'b010; id_reg_write = 1; id_dst_sel = 1; id_rd = 8;
    tick();
    idle();
    exmem_reg_write = 1; exmem_rd = 4; exmem_result = 32'hAAAA;
    memwb_reg_write = 1; memwb_rd = 4; memwb_result = 32'hBBBB;
    #1;
    checks++;
    if (alu_a !== 32'hAAAA) begin
      errors++;
      $display("FAIL fwd_exmem_prio got a=%h exp 0000aaaa", alu_a);
    end
    exmem_reg_write = 0;
    #1;
    checks++;
    if (alu_a !== 32'hBBBB) begin
      errors++;
      $display("FAIL fwd_memwb got a=%h exp 0000bbbb", alu_a);
    end
    memwb_reg_write = 0;
    exmem_reg_write = 1; exmem_rd = 6; exmem_result = 32'hCAFE;
    #1;
    checks++;
    if (alu_a !== 32'h1111 || alu_b !== 32'hCAFE || ex_store_data !== 32'hCAFE) begin
      errors++;
      $display("FAIL fwd_rt got a=%h b=%h sd=%h exp 00001111 0000cafe 0000cafe",
               alu_a, alu_b, ex_store_data);
    end
    // Stall holds EX contents while forwarding still tracks live sources
    stall = 1; id_valid = 1; id_rs = 13; id_rs_data = 32'h9999; flush = 1;
    tick();
    exmem_reg_write = 0; memwb_reg_write = 1; memwb_rd = 4; memwb_result = 32'h4444;
    #1;
    checks++;
    if (alu_a !== 32'h4444 || ex_dst !== 5'd8 || ex_valid !== 1'b1 || alu_b !== 32'h2222) begin
      errors++;
      $display("FAIL stall_fwd got a=%h b=%h dst=%0d v=%b exp 00004444 00002222 8 1",
               alu_a, alu_b, ex_dst, ex_valid);
    end
    // Register 0 never forwards
    idle();
    id_valid = 1; id_rs = 0; id_rt = 0; id_alu_ctrl = 3'b010;
    tick();
    idle();
    exmem_reg_write = 1; exmem_rd = 0; exmem_result = 32'h1234;
    memwb_reg_write = 1; memwb_rd = 0; memwb_result = 32'h5678;
    #1;
    checks++;
    if (alu_a !== 32'd0 || alu_b !== 32'd0) begin
      errors++;
      $display("FAIL fwd_r0 got a=%h b=%h exp 0 0", alu_a, alu_b);
    end
  endtask

  task automatic test_load_use();
    idle();
    // LW r7, 4(r2)
    id_valid = 1; id_rs = 2; id_rt = 7; id_rs_data = 32'h100; id_imm = 16'd4; id_sign_ext = 1;
    id_alu_src = 1; id_alu_ctrl = 3'b010; id_mem_read = 1; id_reg_write = 1;
    tick();
    // ADD r9, r7, r8 waiting in ID
    idle();
    id_valid = 1; id_rs = 7; id_rt = 8; id_rd = 9; id_dst_sel = 1; id_uses_rt = 1;
    id_rs_data = 32'h0; id_rt_data = 32'h20; id_alu_ctrl = 3'b010; id_reg_write = 1;
    #1;
    checks++;
    if (load_use_hazard !== 1'b1 || ex_mem_read !== 1'b1 || alu_a !== 32'h100 ||
        alu_b !== 32'h4) begin
      errors++;
      $display("FAIL lu_detect got h=%b mr=%b a=%h b=%h exp 1 1 00000100 00000004",
               load_use_hazard, ex_mem_read, alu_a, alu_b);
    end
    stall = 1;
    #1;
    checks++;
    if (load_use_hazard !== 1'b0) begin
      errors++;
      $display("FAIL lu_stall_mask got h=%b exp 0", load_use_hazard);
    end
    stall = 0;
    tick();
    // Bubble in EX, load in EX/MEM (data not ready yet)
    exmem_reg_write = 1; exmem_rd = 7; exmem_result = 32'hFFFF_0000;
    #1;
    checks++;
    if (ex_valid !== 1'b0 || load_use_hazard !== 1'b0 || ex_reg_write !== 1'b0 ||
        ex_dst !== 5'd0) begin
      errors++;
      $display("FAIL lu_bubble got v=%b h=%b rw=%b dst=%0d exp 0 0 0 0",
               ex_valid, load_use_hazard, ex_reg_write, ex_dst);
    end
    tick();
    // ADD in EX, load in MEM/WB
    exmem_reg_write = 0; exmem_rd = 0;
    memwb_reg_write = 1; memwb_rd = 7; memwb_result = 32'hDEAD;
    id_valid = 0;
    #1;
    checks++;
    if (ex_valid !== 1'b1 || alu_a !== 32'hDEAD || alu_b !== 32'h20 || ex_dst !== 5'd9) begin
      errors++;
      $display("FAIL lu_forward got v=%b a=%h b=%h dst=%0d exp 1 0000dead 00000020 9",
               ex_valid, alu_a, alu_b, ex_dst);
    end
  endtask

  task automatic test_shift();
    idle();
    id_valid = 1; id_rt = 10; id_rd = 11; id_dst_sel = 1; id_rt_data = 32'h3; id_shamt = 5'd4;
    id_shift = 1; id_uses_rt = 1; id_alu_ctrl = 3'b101; id_reg_write = 1; id_rs_data = 32'h77;
    tick();
    idle();
    #1;
    checks++;
    if (alu_a !== 32'd4 || alu_b !== 32'd3 || alu_ctrl !== 3'b101 || ex_dst !== 5'd11) begin
      errors++;
      $display("FAIL sll got a=%h b=%h ctrl=%b dst=%0d exp 4 3 101 11",
               alu_a, alu_b, alu_ctrl, ex_dst);
    end
  endtask

  task automatic test_stall_flush();
    idle();
    id_valid = 1; id_rs = 3; id_rs_data = 32'h31; id_rd = 12; id_dst_sel = 1;
    id_alu_ctrl = 3'b110; id_reg_write = 1; id_mem_write = 1;
    tick();
    idle();
    id_valid = 1; id_rd = 14; id_dst_sel = 1; id_reg_write = 1;
    flush = 1; stall = 1;
    tick();
    checks++;
    if (ex_valid !== 1'b1 || ex_dst !== 5'd12 || alu_a !== 32'h31 || alu_ctrl !== 3'b110) begin
      errors++;
      $display("FAIL flush_stall_hold got v=%b dst=%0d a=%h ctrl=%b exp 1 12 00000031 110",
               ex_valid, ex_dst, alu_a, alu_ctrl);
    end
    stall = 0;
    tick();
    checks++;
    if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_mem_write !== 1'b0 ||
        ex_dst !== 5'd0 || alu_a !== 32'd0 || alu_ctrl !== 3'b000) begin
      errors++;
      $display("FAIL flush_bubble got v=%b rw=%b mw=%b dst=%0d a=%h ctrl=%b exp all 0",
               ex_valid, ex_reg_write, ex_mem_write, ex_dst, alu_a, alu_ctrl);
    end
    // Write-back bypass at capture on both source indices
    idle();
    id_valid = 1; id_rs = 9; id_rt = 9; id_rs_data = 32'h999; id_rt_data = 32'h999;
    id_alu_ctrl = 3'b011; id_uses_rt = 1;
    memwb_reg_write = 1; memwb_rd = 9; memwb_result = 32'h4242;
    tick();
    idle();
    #1;
    checks++;
    if (alu_a !== 32'h4242 || alu_b !== 32'h4242) begin
      errors++;
      $display("FAIL wb_bypass got a=%h b=%h exp 00004242 00004242", alu_a, alu_b);
    end
    // Reset mid-pipeline beats stall
    reset = 1; stall = 1;
    tick();
    idle();
    #1;
    checks++;
    if (ex_valid !== 1'b0 || alu_a !== 32'd0 || alu_b !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid got v=%b a=%h b=%h exp 0 0 0", ex_valid, alu_a, alu_b);
    end
  endtask

  initial begin
    test_reset();
    test_immediate();
    test_forwarding();
    test_load_use();
    test_shift();
    test_stall_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
